// File: rtl/regfile_mp_pkg.sv
// Shared defaults and limits for the multi-port register file.
//   DW_DEF / AW_DEF   : default data / address width
//   NRD_MAX / NWR_MAX : upper limits on read / write port counts
//   nregs()           : number of registers for a given address width
package regfile_mp_pkg;

    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int NRD_MAX = 4;
    localparam int NWR_MAX = 2;

    function automatic int nregs(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, an incrementally
// maintained busy count, and per-read-port operand-ready flags.
//   Clk, Clrn      : clock, synchronous active-low reset
//   i_ra           : flattened read addresses (NRD x AW)
//   i_we, i_wr     : write enables and flattened write addresses
//   i_bset, i_baddr: mark register i_baddr pending
//   o_rdy          : per read port, operand not pending
//   o_nbusy        : number of pending registers
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [NRD*AW-1:0] i_ra,
    input  logic [NWR-1:0]    i_we,
    input  logic [NWR*AW-1:0] i_wr,
    input  logic              i_bset,
    input  logic [AW-1:0]     i_baddr,
    output logic [NRD-1:0]    o_rdy,
    output logic [AW:0]       o_nbusy
);

    localparam int NR = 1 << AW;

    logic [NR-1:0] r_busy;
    logic [AW:0]   r_nbusy;
    logic [NR-1:0] w_set;
    logic [NR-1:0] w_clr;
    logic          w_inc;
    logic [AW:0]   w_dec;
    logic          w_last;
    logic          w_hit;

    always_comb begin
        w_set = '0;
        w_inc = 1'b0;
        if (i_bset && !(ZERO_R0 && i_baddr == '0)) begin
            w_set[i_baddr] = 1'b1;
            w_inc          = !r_busy[i_baddr];
        end
    end

    // Each cleared busy register is counted once: only the highest-index
    // port writing a given address contributes to the decrement.
    always_comb begin
        w_clr  = '0;
        w_dec  = '0;
        w_last = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            if (i_we[j] && !(ZERO_R0 && i_wr[j*AW +: AW] == '0)) begin
                w_clr[i_wr[j*AW +: AW]] = 1'b1;
                w_last = 1'b1;
                for (int k = j + 1; k < NWR; k++) begin
                    if (i_we[k] && i_wr[k*AW +: AW] == i_wr[j*AW +: AW])
                        w_last = 1'b0;
                end
                if (w_last && r_busy[i_wr[j*AW +: AW]] && !w_set[i_wr[j*AW +: AW]])
                    w_dec = w_dec + 1'b1;
            end
        end
    end

    // Set wins over clear: a newly issued producer supersedes the writeback.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            r_busy  <= '0;
            r_nbusy <= '0;
        end else begin
            r_busy  <= (r_busy & ~w_clr) | w_set;
            r_nbusy <= r_nbusy + {{AW{1'b0}}, w_inc} - w_dec;
        end
    end

    always_comb begin
        o_rdy = '0;
        w_hit = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            w_hit = 1'b0;
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (i_we[j] && i_wr[j*AW +: AW] == i_ra[i*AW +: AW])
                        w_hit = 1'b1;
                end
            end
            o_rdy[i] = !r_busy[i_ra[i*AW +: AW]] || w_hit
                       || (ZERO_R0 && i_ra[i*AW +: AW] == '0);
        end
    end

    assign o_nbusy = r_nbusy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass, optional hardwired
// zero register and a pending-write scoreboard.
//   Clk, Clrn : clock, synchronous active-low reset
//   Ra / Qa   : flattened read addresses / read data (NRD ports)
//   Rdy       : per read port, operand valid
//   We, Wr, D : write enables, flattened write addresses and data (NWR ports)
//   Bset/Baddr: mark a register pending
//   Nbusy     : number of pending registers
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [NRD*AW-1:0] Ra,
    output logic [NRD*DW-1:0] Qa,
    output logic [NRD-1:0]    Rdy,
    input  logic [NWR-1:0]    We,
    input  logic [NWR*AW-1:0] Wr,
    input  logic [NWR*DW-1:0] D,
    input  logic              Bset,
    input  logic [AW-1:0]     Baddr,
    output logic [AW:0]       Nbusy
);

    localparam int NR = nregs(AW);

    logic [DW-1:0] r_mem [NR];
    logic [DW-1:0] w_q   [NRD];

    // Ascending port order makes the highest-index port win on a conflict.
    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            for (int r = 0; r < NR; r++)
                r_mem[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (We[j] && !(ZERO_R0 && Wr[j*AW +: AW] == '0))
                    r_mem[Wr[j*AW +: AW]] <= D[j*DW +: DW];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            w_q[i] = r_mem[Ra[i*AW +: AW]];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (We[j] && Wr[j*AW +: AW] == Ra[i*AW +: AW])
                        w_q[i] = D[j*DW +: DW];
                end
            end
            if (ZERO_R0 && Ra[i*AW +: AW] == '0)
                w_q[i] = '0;
        end
    end

    always_comb begin
        Qa = '0;
        for (int i = 0; i < NRD; i++)
            Qa[i*DW +: DW] = w_q[i];
    end

    regfile_mp_scoreboard #(
        .AW      (AW),
        .NRD     (NRD),
        .NWR     (NWR),
        .BYPASS  (BYPASS),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .Clk     (Clk),
        .Clrn    (Clrn),
        .i_ra    (Ra),
        .i_we    (We),
        .i_wr    (Wr),
        .i_bset  (Bset),
        .i_baddr (Baddr),
        .o_rdy   (Rdy),
        .o_nbusy (Nbusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic [9:0]  Ra;
    logic [63:0] Qa;
    logic [1:0]  Rdy;
    logic [1:0]  We;
    logic [9:0]  Wr;
    logic [63:0] D;
    logic        Bset;
    logic [4:0]  Baddr;
    logic [5:0]  Nbusy;

    logic [63:0] nb_Qa;
    logic [1:0]  nb_Rdy;
    logic [5:0]  nb_Nbusy;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Qa(Qa), .Rdy(Rdy), .We(We),
        .Wr(Wr), .D(D), .Bset(Bset), .Baddr(Baddr), .Nbusy(Nbusy)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Qa(nb_Qa), .Rdy(nb_Rdy), .We(We),
        .Wr(Wr), .D(D), .Bset(Bset), .Baddr(Baddr), .Nbusy(nb_Nbusy)
    );

    typedef struct {
        logic        clrn;
        logic [1:0]  we;
        logic [4:0]  wr0, wr1;
        logic [31:0] d0, d1;
        logic        bset;
        logic [4:0]  baddr;
        logic [4:0]  ra0, ra1;
        logic [31:0] eq0, eq1, enq0;
        logic [1:0]  erdy;
        logic [5:0]  enb;
    } vec_t;

    vec_t vec [22];

    function automatic vec_t mk(input logic clrn, input logic [1:0] we,
                                input logic [4:0] wr0, input logic [31:0] d0,
                                input logic [4:0] wr1, input logic [31:0] d1,
                                input logic bset, input logic [4:0] baddr,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] eq0, input logic [31:0] eq1,
                                input logic [31:0] enq0, input logic [1:0] erdy,
                                input logic [5:0] enb);
        vec_t v;
        v.clrn = clrn; v.we = we; v.wr0 = wr0; v.d0 = d0; v.wr1 = wr1; v.d1 = d1;
        v.bset = bset; v.baddr = baddr; v.ra0 = ra0; v.ra1 = ra1;
        v.eq0 = eq0; v.eq1 = eq1; v.enq0 = enq0; v.erdy = erdy; v.enb = enb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        Clrn = 1'b1; We = '0; Wr = '0; D = '0; Bset = 1'b0; Baddr = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        idle();
        Clrn = 1'b0;
        Ra   = '0;
        @(negedge Clk);
        tick();
        tick();
        idle();

        // Reset state: every address reads 0, all ready, nothing pending.
        for (int a = 0; a < 32; a++) begin
            Ra = {5'(31 - a), 5'(a)};
            #2;
            chk($sformatf("rst_q0[%0d]", a), Qa[31:0], 64'd0);
            chk($sformatf("rst_q1[%0d]", 31 - a), Qa[63:32], 64'd0);
            chk("rst_rdy", Rdy, 64'd3);
            chk("rst_nbusy", Nbusy, 64'd0);
            @(negedge Clk);
        end

        //            clrn we    wr0 d0    wr1 d1   bset ba  ra0 ra1 eq0  eq1  enq0 erdy enb
        vec[0]  = mk(1, 2'b01, 5,  666, 0,  0,  0,   0,  5,  0,  666, 0,   0,   3,   0);
        vec[1]  = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  5,  0,  666, 0,   666, 3,   0);
        vec[2]  = mk(1, 2'b11, 7,  1,   7,  2,  0,   0,  7,  5,  2,   666, 0,   3,   0);
        vec[3]  = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  7,  5,  2,   666, 2,   3,   0);
        vec[4]  = mk(1, 2'b01, 0,  99,  0,  0,  0,   0,  0,  7,  0,   2,   0,   3,   0);
        vec[5]  = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  0,  7,  0,   2,   0,   3,   0);
        vec[6]  = mk(1, 2'b00, 0,  0,   0,  0,  1,   9,  1,  9,  0,   0,   0,   3,   0);
        vec[7]  = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  1,  9,  0,   0,   0,   1,   1);
        vec[8]  = mk(1, 2'b10, 0,  0,   9,  12, 0,   0,  1,  9,  0,   12,  0,   3,   1);
        vec[9]  = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  1,  9,  0,   12,  0,   3,   0);
        vec[10] = mk(1, 2'b01, 9,  33,  0,  0,  1,   9,  1,  9,  0,   33,  0,   3,   0);
        vec[11] = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  1,  9,  0,   33,  0,   1,   1);
        vec[12] = mk(1, 2'b11, 9,  4,   9,  5,  0,   0,  1,  9,  0,   5,   0,   3,   1);
        vec[13] = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  1,  9,  0,   5,   0,   3,   0);
        vec[14] = mk(1, 2'b00, 0,  0,   0,  0,  1,   0,  0,  9,  0,   5,   0,   3,   0);
        vec[15] = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  0,  9,  0,   5,   0,   3,   0);
        vec[16] = mk(1, 2'b00, 0,  0,   0,  0,  1,   3,  1,  1,  0,   0,   0,   3,   0);
        vec[17] = mk(1, 2'b00, 0,  0,   0,  0,  1,   4,  3,  1,  0,   0,   0,   2,   1);
        vec[18] = mk(1, 2'b01, 10, 5,   0,  0,  0,   0,  4,  10, 0,   5,   0,   2,   2);
        vec[19] = mk(0, 2'b01, 11, 7,   0,  0,  1,   5,  3,  10, 0,   5,   0,   2,   2);
        vec[20] = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  3,  10, 0,   0,   0,   3,   0);
        vec[21] = mk(1, 2'b00, 0,  0,   0,  0,  0,   0,  11, 5,  0,   0,   0,   3,   0);

        for (int n = 0; n < 22; n++) begin
            Clrn  = vec[n].clrn;
            We    = vec[n].we;
            Wr    = {vec[n].wr1, vec[n].wr0};
            D     = {vec[n].d1, vec[n].d0};
            Bset  = vec[n].bset;
            Baddr = vec[n].baddr;
            Ra    = {vec[n].ra1, vec[n].ra0};
            #2;
            chk($sformatf("v%0d_q0", n), Qa[31:0], vec[n].eq0);
            chk($sformatf("v%0d_q1", n), Qa[63:32], vec[n].eq1);
            chk($sformatf("v%0d_nbq0", n), nb_Qa[31:0], vec[n].enq0);
            chk($sformatf("v%0d_rdy", n), Rdy, vec[n].erdy);
            chk($sformatf("v%0d_nbusy", n), Nbusy, vec[n].enb);
            tick();
        end
        idle();

        // Fill the scoreboard completely, one register per cycle.
        for (int r = 1; r < 32; r++) begin
            Bset = 1'b1; Baddr = 5'(r);
            tick();
            Bset = 1'b0;
            #1;
            chk($sformatf("fill_nbusy[%0d]", r), Nbusy, 64'(r));
        end
        Bset = 1'b1; Baddr = 5'd5;
        tick();
        Bset = 1'b0;
        #1;
        chk("reset_busy_again", Nbusy, 64'd31);
        Ra = {5'd20, 5'd31};
        #1;
        chk("full_rdy", Rdy, 64'd0);

        // Drain two registers per cycle through both write ports.
        for (int r = 1; r < 32; r += 2) begin
            We = (r == 31) ? 2'b01 : 2'b11;
            Wr = {5'(r + 1), 5'(r)};
            D  = {32'(r + 1), 32'(r)};
            tick();
            idle();
            #1;
            chk($sformatf("drain_nbusy[%0d]", r), Nbusy, 64'((r == 31) ? 0 : 30 - r));
        end
        Ra = {5'd20, 5'd31};
        #1;
        chk("drain_q0", Qa[31:0], 64'd31);
        chk("drain_q1", Qa[63:32], 64'd20);
        chk("drain_rdy", Rdy, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
